pulse_train_gen: RTL and testbench

- Transmit-side companion to the edge detectors. Generates a clean level waveform with programmed high and low phase lengths, repeated a programmed number of times.
- Emits cycle-aligned rise/fall markers alongside the level, so downstream edge-detect logic and benches can be checked against a known truth.
- Used as a stimulus and strobe source inside the design.

---
 rtl/pulse_train_gen_if.sv | 27 ++
 rtl/pulse_train_gen.sv | 127 ++++++++++++
 tb/tb_pulse_train_gen.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_train_gen_if.sv
// Handshake and parameter bundle for pulse_train_gen: requests and lengths in,
// level, edge markers and completion status out.
interface pulse_train_gen_if #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
);
  logic             start_i;
  logic             stop_i;
  logic [LEN_W-1:0] high_len_i;
  logic [LEN_W-1:0] low_len_i;
  logic [CNT_W-1:0] count_i;
  logic             ready_o;
  logic             wave_o;
  logic             rise_o;
  logic             fall_o;
  logic             done_o;

  modport master (
    output start_i, stop_i, high_len_i, low_len_i, count_i,
    input  ready_o, wave_o, rise_o, fall_o, done_o
  );

  modport slave (
    input  start_i, stop_i, high_len_i, low_len_i, count_i,
    output ready_o, wave_o, rise_o, fall_o, done_o
  );
endinterface

// File: rtl/pulse_train_gen.sv
// Pulse train generator: programmed high/low phases repeated count times, with
// registered level, rise/fall markers and done. Define PULSE_TRAIN_INFINITE_EN to make count=0 run until stopped.
module pulse_train_gen #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
) (
  input logic             clk,
  input logic             reset,
  pulse_train_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state, state_n;
  logic [LEN_W-1:0] phase_cnt, phase_cnt_n;
  logic [LEN_W-1:0] high_len, high_len_n;
  logic [LEN_W-1:0] low_len, low_len_n;
  logic [CNT_W-1:0] period_cnt, period_cnt_n;
  logic             wave, rise, rise_n, fall, fall_n, done, done_n, ready;
  logic             infinite, zero_done;

  // Zero-length phases are stretched to one cycle so every edge stays visible.
  function automatic logic [LEN_W-1:0] at_least_one(input logic [LEN_W-1:0] v);
    return (v == '0) ? LEN_W'(1) : v;
  endfunction

`ifdef PULSE_TRAIN_INFINITE_EN
  assign infinite  = (period_cnt == '0);
  assign zero_done = 1'b0;
`else
  assign infinite  = 1'b0;
  assign zero_done = (bus.count_i == '0);
`endif

  always_comb begin
    state_n      = state;
    phase_cnt_n  = phase_cnt;
    period_cnt_n = period_cnt;
    high_len_n   = high_len;
    low_len_n    = low_len;
    rise_n       = 1'b0;
    fall_n       = 1'b0;
    done_n       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_i && !bus.stop_i) begin
          high_len_n   = bus.high_len_i;
          low_len_n    = bus.low_len_i;
          period_cnt_n = bus.count_i;
          if (zero_done) begin
            done_n = 1'b1;
          end else begin
            state_n     = HIGH;
            phase_cnt_n = at_least_one(bus.high_len_i);
            rise_n      = 1'b1;
          end
        end
      end
      HIGH: begin
        if (bus.stop_i) begin
          state_n = IDLE;
          fall_n  = 1'b1;
          done_n  = 1'b1;
        end else if (phase_cnt <= LEN_W'(1)) begin
          state_n     = LOW;
          phase_cnt_n = at_least_one(low_len);
          fall_n      = 1'b1;
        end else begin
          phase_cnt_n = phase_cnt - LEN_W'(1);
        end
      end
      LOW: begin
        if (bus.stop_i) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (phase_cnt <= LEN_W'(1)) begin
          if (!infinite && period_cnt <= CNT_W'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            if (!infinite) period_cnt_n = period_cnt - CNT_W'(1);
            state_n     = HIGH;
            phase_cnt_n = at_least_one(high_len);
            rise_n      = 1'b1;
          end
        end else begin
          phase_cnt_n = phase_cnt - LEN_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      phase_cnt  <= '0;
      period_cnt <= '0;
      high_len   <= '0;
      low_len    <= '0;
      wave       <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      done       <= 1'b0;
      ready      <= 1'b1;
    end else begin
      state      <= state_n;
      phase_cnt  <= phase_cnt_n;
      period_cnt <= period_cnt_n;
      high_len   <= high_len_n;
      low_len    <= low_len_n;
      wave       <= (state_n == HIGH);
      rise       <= rise_n;
      fall       <= fall_n;
      done       <= done_n;
      ready      <= (state_n == IDLE);
    end
  end

  assign bus.wave_o  = wave;
  assign bus.rise_o  = rise;
  assign bus.fall_o  = fall;
  assign bus.done_o  = done;
  assign bus.ready_o = ready;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: expected {ready,wave,rise,fall,done}
// per cycle is queued from the programmed lengths and compared cycle by cycle.
module tb_pulse_train_gen;

  localparam int LEN_W = 8;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [4:0] exp_q[$];
  logic [4:0] got;
  logic [4:0] exp_v;

  pulse_train_gen_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  pulse_train_gen #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign got = {bus.ready_o, bus.wave_o, bus.rise_o, bus.fall_o, bus.done_o};

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Expected trace of cnt full periods, from the programmed lengths.
  task automatic push_train(input int hi, input int lo, input int cnt);
    int h;
    int l;
    h = (hi == 0) ? 1 : hi;
    l = (lo == 0) ? 1 : lo;
    for (int p = 0; p < cnt; p++) begin
      for (int i = 0; i < h; i++) exp_q.push_back((i == 0) ? 5'b01100 : 5'b01000);
      for (int i = 0; i < l; i++) exp_q.push_back((i == 0) ? 5'b00010 : 5'b00000);
    end
  endtask

  task automatic push_n(input logic [4:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic start_req(input int hi, input int lo, input int cnt);
    @(negedge clk);
    bus.start_i    = 1'b1;
    bus.high_len_i = LEN_W'(hi);
    bus.low_len_i  = LEN_W'(lo);
    bus.count_i    = CNT_W'(cnt);
    @(posedge clk);
    #1 bus.start_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (got !== 5'b10000) begin
        errors++;
        $display("[TB] FAIL reset_state got %b expected %b", got, 5'b10000);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (got !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL idle_after_reset got %b expected %b", got, 5'b10000);
    end
  endtask

  task automatic test_basic(input int hi, input int lo, input int cnt, input string name);
    int cyc;
    push_train(hi, lo, cnt);
    push_n(5'b10001, 1);
    push_n(5'b10000, 2);
    start_req(hi, lo, cnt);
    cyc = 1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("[TB] FAIL %s cycle %0d got %b expected %b", name, cyc, got, exp_v);
      end
      cyc++;
    end
  endtask

  task automatic test_stop_high();
    int cyc;
    push_train(5, 5, 1);
    exp_q = exp_q[0:2];
    push_n(5'b10011, 1);
    push_n(5'b10000, 4);
    start_req(5, 5, 4);
    cyc = 1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("[TB] FAIL stop_high cycle %0d got %b expected %b", cyc, got, exp_v);
      end
      if (cyc == 3) bus.stop_i = 1'b1;
      if (cyc == 4) bus.stop_i = 1'b0;
      cyc++;
    end
  endtask

  task automatic test_stop_low();
    int cyc;
    push_n(5'b01100, 1);
    push_n(5'b00010, 1);
    push_n(5'b10001, 1);
    push_n(5'b10000, 2);
    start_req(1, 3, 2);
    cyc = 1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("[TB] FAIL stop_low cycle %0d got %b expected %b", cyc, got, exp_v);
      end
      if (cyc == 2) bus.stop_i = 1'b1;
      if (cyc == 3) bus.stop_i = 1'b0;
      cyc++;
    end
  endtask

  task automatic test_busy_start();
    int cyc;
    push_train(3, 2, 2);
    push_n(5'b10001, 1);
    push_n(5'b10000, 2);
    start_req(3, 2, 2);
    cyc = 1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("[TB] FAIL busy_start cycle %0d got %b expected %b", cyc, got, exp_v);
      end
      if (cyc == 1) begin
        bus.start_i    = 1'b1;
        bus.high_len_i = 8'd7;
        bus.low_len_i  = 8'd6;
        bus.count_i    = 8'd5;
      end
      if (cyc == 2) bus.start_i = 1'b0;
      cyc++;
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    push_train(3, 2, 1);
    push_n(5'b10000, 4);
    start_req(3, 2, 2);
    cyc = 1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("[TB] FAIL reset_mid cycle %0d got %b expected %b", cyc, got, exp_v);
      end
      if (cyc == 5) reset = 1'b1;
      if (cyc == 6) reset = 1'b0;
      cyc++;
    end
  endtask

  task automatic test_stop_idle();
    int cyc;
    push_n(5'b10000, 4);
    @(negedge clk);
    bus.start_i    = 1'b1;
    bus.stop_i     = 1'b1;
    bus.high_len_i = 8'd2;
    bus.low_len_i  = 8'd2;
    bus.count_i    = 8'd2;
    cyc = 1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("[TB] FAIL stop_idle cycle %0d got %b expected %b", cyc, got, exp_v);
      end
      if (cyc == 1) begin
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
      end
      cyc++;
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    push_train(1, 1, 1);
    push_n(5'b10001, 1);
    push_train(2, 1, 1);
    push_n(5'b10001, 1);
    push_n(5'b10000, 1);
    start_req(1, 1, 1);
    cyc = 1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("[TB] FAIL back_to_back cycle %0d got %b expected %b", cyc, got, exp_v);
      end
      if (cyc == 3) begin
        bus.start_i    = 1'b1;
        bus.high_len_i = 8'd2;
        bus.low_len_i  = 8'd1;
        bus.count_i    = 8'd1;
      end
      if (cyc == 4) bus.start_i = 1'b0;
      cyc++;
    end
  endtask

  task automatic test_count_zero();
    int cyc;
`ifdef PULSE_TRAIN_INFINITE_EN
    push_train(1, 1, 60);
    push_n(5'b10001, 1);
    push_n(5'b10000, 2);
    start_req(1, 1, 0);
`else
    push_n(5'b10001, 1);
    push_n(5'b10000, 3);
    start_req(1, 1, 0);
`endif
    cyc = 1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("[TB] FAIL count_zero cycle %0d got %b expected %b", cyc, got, exp_v);
      end
`ifdef PULSE_TRAIN_INFINITE_EN
      if (cyc == 120) bus.stop_i = 1'b1;
      if (cyc == 121) bus.stop_i = 1'b0;
`endif
      cyc++;
    end
  endtask

  initial begin
    bus.start_i    = 1'b0;
    bus.stop_i     = 1'b0;
    bus.high_len_i = '0;
    bus.low_len_i  = '0;
    bus.count_i    = '0;
    test_reset();
    test_basic(3, 2, 2, "basic_3_2_2");
    test_basic(0, 0, 3, "zero_len_0_0_3");
    test_basic(4, 1, 1, "single_4_1_1");
    test_stop_high();
    test_stop_low();
    test_busy_start();
    test_reset_mid();
    test_stop_idle();
    test_back_to_back();
    test_count_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
